// File: rtl/alu_issue_ctrl_if.sv
// Bundles the request, ALU-facing and response channels of alu_issue_ctrl.
// master: the surrounding datapath (requester, ALU, response consumer).
// slave:  the issue controller itself.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_lt;
    logic             alu_gt;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_lt;
    logic             rsp_gt;
    logic             rsp_illegal;

    modport master (
        output req_valid, req_funct, req_a, req_b, rsp_ready,
               alu_result, alu_zero, alu_lt, alu_gt,
        input  req_ready, alu_data1, alu_data2, alu_op,
               rsp_valid, rsp_result, rsp_zero, rsp_lt, rsp_gt, rsp_illegal
    );

    modport slave (
        input  req_valid, req_funct, req_a, req_b, rsp_ready,
               alu_result, alu_zero, alu_lt, alu_gt,
        output req_ready, alu_data1, alu_data2, alu_op,
               rsp_valid, rsp_result, rsp_zero, rsp_lt, rsp_gt, rsp_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts an R-type request,
// holds the ALU inputs for SETTLE_CYCLES, captures result/flags and
// presents them on a valid/ready response channel.
module alu_issue_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1   // 1..15
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept, capture;
    logic [3:0]       op_dec;
    logic             ill_dec;

    logic [WIDTH-1:0] data1_q, data2_q;
    logic [3:0]       op_q;
    logic             ill_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, lt_q, gt_q;

    // Funct -> ALU operation code; unsupported codes fall back to ADD.
    always_comb begin
        op_dec  = 4'b0000;
        ill_dec = 1'b0;
        case (bus.req_funct)
            6'h20, 6'h21: op_dec = 4'b0000;
            6'h22, 6'h23: op_dec = 4'b0001;
            6'h24:        op_dec = 4'b0010;
            6'h25:        op_dec = 4'b0011;
            6'h26:        op_dec = 4'b0100;
            6'h2A, 6'h2B: op_dec = 4'b0101;
            default:      ill_dec = 1'b1;
        endcase
    end

    // Next-state, settle countdown and accept/capture strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = DRIVE;
            end
            DRIVE: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ALU operands/op only change at accept so the ALU sees stable inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q <= '0;
            data2_q <= '0;
            op_q    <= 4'd0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            data1_q <= bus.req_a;
            data2_q <= bus.req_b;
            op_q    <= op_dec;
            ill_q   <= ill_dec;
        end
    end

    // Response capture; the ALU leaves lt/gt stale on equal operands, so mask them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else if (capture) begin
            res_q  <= bus.alu_result;
            zero_q <= bus.alu_zero;
            lt_q   <= (data1_q != data2_q) && bus.alu_lt;
            gt_q   <= (data1_q != data2_q) && bus.alu_gt;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.alu_data1   = data1_q;
    assign bus.alu_data2   = data2_q;
    assign bus.alu_op      = op_q;
    assign bus.rsp_result  = res_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_lt      = lt_q;
    assign bus.rsp_gt      = gt_q;
    assign bus.rsp_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with SETTLE_CYCLES=1 and
// one with SETTLE_CYCLES=4, each wired to a small behavioural ALU whose
// lt/gt flags hold their old value when the operands are equal.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(32)) b1 ();
    alu_issue_ctrl_if #(.WIDTH(32)) b4 ();

    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // Behavioural ALU for instance 1 (lt/gt not updated on equality).
    logic lt1 = 1'b0, gt1 = 1'b0;
    always @* if (b1.alu_data1 != b1.alu_data2) begin
        lt1 = b1.alu_data1 < b1.alu_data2;
        gt1 = b1.alu_data1 > b1.alu_data2;
    end
    always @* begin
        case (b1.alu_op)
            4'd0:    b1.alu_result = b1.alu_data1 + b1.alu_data2;
            4'd1:    b1.alu_result = b1.alu_data1 - b1.alu_data2;
            4'd2:    b1.alu_result = b1.alu_data1 & b1.alu_data2;
            4'd3:    b1.alu_result = b1.alu_data1 | b1.alu_data2;
            4'd4:    b1.alu_result = b1.alu_data1 ^ b1.alu_data2;
            4'd5:    b1.alu_result = {31'd0, lt1};
            default: b1.alu_result = 32'd0;
        endcase
    end
    assign b1.alu_zero = (b1.alu_result == 32'd0);
    assign b1.alu_lt   = lt1;
    assign b1.alu_gt   = gt1;

    // Behavioural ALU for instance 4.
    logic lt4 = 1'b0, gt4 = 1'b0;
    always @* if (b4.alu_data1 != b4.alu_data2) begin
        lt4 = b4.alu_data1 < b4.alu_data2;
        gt4 = b4.alu_data1 > b4.alu_data2;
    end
    always @* begin
        case (b4.alu_op)
            4'd0:    b4.alu_result = b4.alu_data1 + b4.alu_data2;
            4'd1:    b4.alu_result = b4.alu_data1 - b4.alu_data2;
            4'd2:    b4.alu_result = b4.alu_data1 & b4.alu_data2;
            4'd3:    b4.alu_result = b4.alu_data1 | b4.alu_data2;
            4'd4:    b4.alu_result = b4.alu_data1 ^ b4.alu_data2;
            4'd5:    b4.alu_result = {31'd0, lt4};
            default: b4.alu_result = 32'd0;
        endcase
    end
    assign b4.alu_zero = (b4.alu_result == 32'd0);
    assign b4.alu_lt   = lt4;
    assign b4.alu_gt   = gt4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the SETTLE_CYCLES=1 instance, rsp_ready high
    // only once the response is seen (accept edge + 1 edge -> rsp_valid).
    task automatic op1(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] eop, input logic [31:0] eres,
                       input logic ez, input logic elt, input logic egt, input logic eill);
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_funct = f; b1.req_a = a; b1.req_b = b;
        chk({tag, ".ready_idle"}, 32'(b1.req_ready), 32'd1);
        @(negedge clk);                       // accept edge passed
        b1.req_valid = 1'b0;
        chk({tag, ".op"}, 32'(b1.alu_op), 32'(eop));
        chk({tag, ".d1"}, b1.alu_data1, a);
        chk({tag, ".d2"}, b1.alu_data2, b);
        chk({tag, ".valid_early"}, 32'(b1.rsp_valid), 32'd0);
        chk({tag, ".ready_busy"}, 32'(b1.req_ready), 32'd0);
        @(negedge clk);                       // second edge: response up
        chk({tag, ".valid"}, 32'(b1.rsp_valid), 32'd1);
        chk({tag, ".result"}, b1.rsp_result, eres);
        chk({tag, ".zero"}, 32'(b1.rsp_zero), 32'(ez));
        chk({tag, ".lt"}, 32'(b1.rsp_lt), 32'(elt));
        chk({tag, ".gt"}, 32'(b1.rsp_gt), 32'(egt));
        chk({tag, ".illegal"}, 32'(b1.rsp_illegal), 32'(eill));
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(b1.rsp_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(b1.req_ready), 32'd1);
    endtask

    initial begin
        b1.req_valid = 1'b0; b1.req_funct = 6'h0; b1.req_a = '0; b1.req_b = '0; b1.rsp_ready = 1'b0;
        b4.req_valid = 1'b0; b4.req_funct = 6'h0; b4.req_a = '0; b4.req_b = '0; b4.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready1", 32'(b1.req_ready), 32'd1);
        chk("rst.valid1", 32'(b1.rsp_valid), 32'd0);
        chk("rst.op1", 32'(b1.alu_op), 32'd0);
        chk("rst.d1", b1.alu_data1, 32'd0);
        chk("rst.res1", b1.rsp_result, 32'd0);
        chk("rst.ill1", 32'(b1.rsp_illegal), 32'd0);
        chk("rst.ready4", 32'(b4.req_ready), 32'd1);
        rst_n = 1'b1;

        // Basic ops on SETTLE_CYCLES=1
        op1("add",   6'h20, 32'd5, 32'd7,  4'd0, 32'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        op1("subeq", 6'h22, 32'd9, 32'd9,  4'd1, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        op1("wrap",  6'h20, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        op1("illeg", 6'h3F, 32'd3, 32'd4,  4'd0, 32'd7,  1'b0, 1'b1, 1'b0, 1'b1);
        op1("subu",  6'h23, 32'd3, 32'd5,  4'd1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        op1("or",    6'h25, 32'hF0, 32'h0F, 4'd3, 32'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        op1("xor",   6'h26, 32'hF0, 32'hFF, 4'd4, 32'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
        op1("sltu",  6'h2B, 32'd10, 32'd2, 4'd5, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of the SETTLE_CYCLES=4 drive window
        @(negedge clk);
        b4.req_valid = 1'b1; b4.req_funct = 6'h21; b4.req_a = 32'd11; b4.req_b = 32'd22;
        @(negedge clk);
        b4.req_valid = 1'b0;
        chk("arst.in_drive", 32'(b4.req_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ready", 32'(b4.req_ready), 32'd1);
        chk("arst.valid", 32'(b4.rsp_valid), 32'd0);
        chk("arst.d1", b4.alu_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst.no_rsp", 32'(b4.rsp_valid), 32'd0);

        // SETTLE_CYCLES=4 SLT with back-pressure and a held second request
        b4.req_valid = 1'b1; b4.req_funct = 6'h2A; b4.req_a = 32'd2; b4.req_b = 32'd10;
        @(negedge clk);                       // accept edge
        b4.req_valid = 1'b0;
        chk("s4.op", 32'(b4.alu_op), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s4.hold_d1", b4.alu_data1, 32'd2);
            chk("s4.hold_d2", b4.alu_data2, 32'd10);
            chk("s4.not_valid", 32'(b4.rsp_valid), 32'd0);
        end
        @(negedge clk);                       // fifth edge: response
        chk("s4.valid", 32'(b4.rsp_valid), 32'd1);
        chk("s4.result", b4.rsp_result, 32'd1);
        chk("s4.lt", 32'(b4.rsp_lt), 32'd1);
        chk("s4.gt", 32'(b4.rsp_gt), 32'd0);
        b4.req_valid = 1'b1; b4.req_funct = 6'h24; b4.req_a = 32'hF0; b4.req_b = 32'h3C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("s4.bp_valid", 32'(b4.rsp_valid), 32'd1);
            chk("s4.bp_result", b4.rsp_result, 32'd1);
            chk("s4.bp_lt", 32'(b4.rsp_lt), 32'd1);
            chk("s4.bp_ready", 32'(b4.req_ready), 32'd0);
            chk("s4.bp_d1", b4.alu_data1, 32'd2);
        end
        b4.rsp_ready = 1'b1;
        @(negedge clk);                       // handshake edge
        b4.rsp_ready = 1'b0;
        chk("s4.hs_valid", 32'(b4.rsp_valid), 32'd0);
        chk("s4.hs_ready", 32'(b4.req_ready), 32'd1);
        chk("s4.hs_noacc", b4.alu_data1, 32'd2);
        @(negedge clk);                       // second request accepted here
        b4.req_valid = 1'b0;
        chk("s4.acc2_d1", b4.alu_data1, 32'hF0);
        chk("s4.acc2_op", 32'(b4.alu_op), 32'd2);
        chk("s4.acc2_ready", 32'(b4.req_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("s4.and_valid", 32'(b4.rsp_valid), 32'd1);
        chk("s4.and_result", b4.rsp_result, 32'h30);
        chk("s4.and_gt", 32'(b4.rsp_gt), 32'd1);
        b4.rsp_ready = 1'b1;
        @(negedge clk);
        b4.rsp_ready = 1'b0;
        chk("s4.end_ready", 32'(b4.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
